// File: rtl/prm_obs_scan.sv
// Obstacle-scan frame accumulator: presents each cell code to the edge checker and tallies the returned masks.
// Optional macro PRM_OBS_HIT_COUNT_EN builds the hit counter; without it res_hits is tied to zero.
module prm_obs_scan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [14:0]      in_code,
    input  logic             in_last,
    output logic [14:0]      chk_code,
    input  logic             chk_mask,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_blocked,
    output logic [CNT_W-1:0] res_npts,
    output logic [CNT_W-1:0] res_hits,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [14:0]      r_code;
    logic             r_last;
    logic             r_blocked;
    logic [CNT_W-1:0] r_npts;
    logic             w_hits_nz;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    // Frame sequencing: accept a code, probe it for one cycle, then hold the result when the frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_code    <= 15'd0;
            r_last    <= 1'b0;
            r_blocked <= 1'b0;
            r_npts    <= CNT_ZERO;
        end else if (flush) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b0;
            r_blocked <= 1'b0;
            r_npts    <= CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_code  <= in_code;
                        r_last  <= in_last;
                        r_state <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    r_blocked <= r_blocked | chk_mask;
                    r_npts    <= sat_inc(r_npts, 1'b1);
                    r_state   <= r_last ? ST_RESULT : ST_IDLE;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_blocked <= 1'b0;
                        r_npts    <= CNT_ZERO;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PRM_OBS_HIT_COUNT_EN
    logic [CNT_W-1:0] r_hits;

    // Hit tally follows the same clear points as the point counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hits <= CNT_ZERO;
        end else if (flush) begin
            r_hits <= CNT_ZERO;
        end else if (r_state == ST_PROBE) begin
            r_hits <= sat_inc(r_hits, chk_mask);
        end else if ((r_state == ST_RESULT) && res_ready) begin
            r_hits <= CNT_ZERO;
        end else begin
            r_hits <= r_hits;
        end
    end

    assign res_hits  = r_hits;
    assign w_hits_nz = |r_hits;
`else
    assign res_hits  = CNT_ZERO;
    assign w_hits_nz = 1'b0;
`endif

    // Flush and reset both block a same-cycle accept, so ready drops with them.
    assign in_ready    = (r_state == ST_IDLE) & ~rst & ~flush;
    assign chk_code    = r_code;
    assign res_valid   = (r_state == ST_RESULT);
    assign res_blocked = r_blocked;
    assign res_npts    = r_npts;
    assign busy        = (r_state != ST_IDLE) | r_blocked | (|r_npts) | w_hits_nz;

endmodule

// File: doc/prm_obs_scan.md
PRM_OBS_SCAN -- requirements
Module: prm_obs_scan

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the point and hit counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  synchronous abort of the current frame.
REQ-005 SHALL have port in_valid  input  1  obstacle cell code offered.
REQ-006 SHALL have port in_ready  output  1  block accepts a code this cycle.
REQ-007 SHALL have port in_code  input  15  obstacle cell code, bit0=A ... bit14=O.
REQ-008 SHALL have port in_last  input  1  code is the final point of the frame.
REQ-009 SHALL have port chk_code  output  15  registered code driven to the edge-check logic inputs A..O.
REQ-010 SHALL have port chk_mask  input  1  edge_mask returned combinationally from the edge-check logic.
REQ-011 SHALL have port res_valid  output  1  frame result available.
REQ-012 SHALL have port res_ready  input  1  consumer takes result.
REQ-013 SHALL have port res_blocked  output  1  any point in the frame obstructed the edge.
REQ-014 SHALL have port res_npts  output  CNT_W  points checked in the frame.
REQ-015 SHALL have port res_hits  output  CNT_W  points with chk_mask=1.
REQ-016 SHALL have port busy  output  1  state is not IDLE, or accumulators are non-zero.

Function
REQ-017 SHALL implement an FSM with states IDLE, PROBE and RESULT.
REQ-018 SHALL assert in_ready only in IDLE.
REQ-019 SHALL, on in_valid&in_ready:
  - load chk_code<=in_code and store in_last;
  - enter PROBE next cycle.
REQ-020 SHALL hold chk_code stable from load until the next accept; chk_code is otherwise never changed except by reset.
REQ-021 SHALL, in PROBE (exactly one cycle), sample chk_mask and update the accumulators:
  - blocked<=blocked|chk_mask;
  - npts+=1;
  - hits+=chk_mask.
REQ-022 SHALL make both counters saturate at 2^CNT_W-1; they never wrap.
REQ-023 SHALL leave PROBE for RESULT if the stored last flag is 1, else for IDLE.
REQ-024 SHALL have a maximum throughput of one point per 2 cycles; accept-to-accumulate latency is 2 cycles.
REQ-025 SHALL assert res_valid only in RESULT, with res_* equal to the accumulators.
REQ-026 SHALL keep res_* stable while res_valid=1 and res_ready=0.
REQ-027 SHALL, on res_valid&res_ready, clear blocked, npts and hits and return to IDLE; in_ready rises the following cycle.
REQ-028 SHALL, on flush=1 in any state, go to IDLE next cycle with accumulators cleared and no result produced; an in_valid in that same cycle is not accepted.
REQ-029 SHALL give rst priority over flush, and flush priority over all handshakes.
REQ-030 SHALL treat a single-point frame (in_last on the first code) as valid: the result carries npts=1.
REQ-031 SHALL, on res_ready=1 outside RESULT, take no action.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set:
  - state=IDLE, chk_code=0, stored last=0, accumulators=0;
  - outputs in_ready=0 during rst, 1 the first cycle after;
  - res_valid=0, res_blocked=0, res_npts=0, res_hits=0, busy=0.
REQ-033 SHALL discard any partial frame or pending result on reset mid-operation; no result is emitted for it.

Configuration
REQ-034 SHALL honour macro PRM_OBS_HIT_COUNT_EN:
  - defined: the hits accumulator and res_hits behave as above;
  - undefined: no hits register is built and res_hits is constant 0; all other behaviour is unchanged.

Verification
REQ-035 SHALL pass this scenario: reset, then frame of 3 codes with chk_mask=0,0,0, res_ready=1 -> res_valid one cycle, res_blocked=0, res_npts=3, res_hits=0.
REQ-036 SHALL pass this scenario: frame of 4 codes with chk_mask=0,1,0,1 -> res_blocked=1, res_npts=4, res_hits=2 (res_hits=0 with macro undefined).
REQ-037 SHALL pass this scenario: result pending, res_ready held 0 for 10 cycles -> res_* stable, in_ready=0 throughout; res_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-038 SHALL pass this scenario: CNT_W=4, 20-point frame with all chk_mask=1 -> res_npts=15, res_hits=15, res_blocked=1.
REQ-039 SHALL pass this scenario: flush asserted in PROBE mid-frame, then a 1-point frame with chk_mask=0 -> result npts=1, blocked=0; no result for the flushed frame.
REQ-040 SHALL pass this scenario: rst pulsed while RESULT pending -> res_valid=0, chk_code=0 next cycle, busy=0.
